// File: rtl/mux4_arb_pkg.sv
// Shared types and constants for the four-requester round-robin output mux.
package mux4_arb_pkg;

  localparam int NREQ = 4;

  typedef logic [1:0] req_idx_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mux2_tree.sv
// Width-generic 4:1 word selector built as a binary tree of 2:1 muxes.
module mux2 #(
  parameter int width = 12
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             sel,
  output logic [width-1:0] y
);

  assign y = sel ? b : a;

endmodule

module mux2_tree #(
  parameter int width = 12
) (
  input  logic [width-1:0] d0,
  input  logic [width-1:0] d1,
  input  logic [width-1:0] d2,
  input  logic [width-1:0] d3,
  input  logic [1:0]       sel,
  output logic [width-1:0] y
);

  logic [width-1:0] lo;
  logic [width-1:0] hi;

  // First level picks within each pair on sel[0]; second level picks the pair.
  mux2 #(.width(width)) u_lo (.a(d0), .b(d1), .sel(sel[0]), .y(lo));
  mux2 #(.width(width)) u_hi (.a(d2), .b(d3), .sel(sel[0]), .y(hi));
  mux2 #(.width(width)) u_top (.a(lo), .b(hi), .sel(sel[1]), .y(y));

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first requester after `last` wins.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  req_idx_t        last,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output req_idx_t        idx
);

  logic found;

  always_comb begin
    gnt   = '0;
    idx   = last;
    found = 1'b0;
    // Search order last+1 .. last+4; the final step wraps back onto last itself.
    for (int k = 1; k <= NREQ; k++) begin
      req_idx_t cand;
      cand = last + req_idx_t'(k);
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbitrated 4:1 word mux with a registered valid/ready output stage.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int width = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [width-1:0] d0,
  input  logic [width-1:0] d1,
  input  logic [width-1:0] d2,
  input  logic [width-1:0] d3,
  output logic [NREQ-1:0]  gnt,
  output logic [width-1:0] y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic [1:0]       s
);

  arb_state_t       state;
  arb_state_t       state_nxt;
  req_idx_t         last;
  req_idx_t         idx_p0;
  logic             load_ok;
  logic             pick_en;
  logic             any_gnt;
  logic [width-1:0] mux_y_p0;
  logic [width-1:0] y_p1;
  req_idx_t         s_p1;

  // Grants are suppressed during reset so no requester believes its word was taken.
  assign load_ok = (state == EMPTY) || y_ready;
  assign pick_en = load_ok && !reset;
  assign any_gnt = |gnt;

  rr_pick4 u_pick (
    .req  (req),
    .last (last),
    .en   (pick_en),
    .gnt  (gnt),
    .idx  (idx_p0)
  );

  mux2_tree #(.width(width)) u_mux (
    .d0  (d0),
    .d1  (d1),
    .d2  (d2),
    .d3  (d3),
    .sel (idx_p0),
    .y   (mux_y_p0)
  );

  always_comb begin
    state_nxt = state;
    if (any_gnt) begin
      state_nxt = FULL;
    end else if ((state == FULL) && y_ready) begin
      state_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // p0 -> p1: capture the granted word; y and s move only on a grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      y_p1 <= '0;
      s_p1 <= '0;
      last <= req_idx_t'(NREQ - 1);
    end else if (any_gnt) begin
      y_p1 <= mux_y_p0;
      s_p1 <= idx_p0;
      last <= idx_p0;
    end
  end

  assign y       = y_p1;
  assign s       = s_p1;
  assign y_valid = (state == FULL);

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Shares one 4:1 word-wide mux between four requesters. A round-robin policy selects which input drives a registered output stage with valid/ready flow control. It sits between four independent word producers and a single consumer, and replaces the free-running select inputs of the 4-input mux with arbitrated, registered ones.

## Interface
- width, 12, data word width in bits
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req  input  4  per-requester request; req[i] means d_i holds a valid word
- d0, d1, d2, d3  input  width  requester data words
- gnt  output  4  one-hot grant; gnt[i] means d_i is captured at this clock edge
- y  output  width  registered output word
- y_valid  output  1  y holds a word not yet accepted
- y_ready  input  1  consumer accepts y when y_valid & y_ready
- s  output  2  index of the requester whose word is currently in y

## Operation
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- State machine, states EMPTY and FULL:
  - EMPTY: y_valid=0.
  - FULL: y_valid=1.
- The output stage can load (`load_ok`) when state==EMPTY, or when state==FULL and y_ready=1.
- Grant: when load_ok and |req, gnt is the one-hot of the winner. Otherwise gnt=0. gnt is combinational.
- Round robin: pointer `last` (2 bits) holds the last granted index. The search order is last+1, last+2, last+3, last (mod 4). The first requester with req set in that order wins.
- On a grant to requester i, at the clock edge:
  - y <= d_i, s <= i, last <= i
  - state <= FULL
- At the edge when state==FULL, y_ready=1 and no req: state <= EMPTY. y and s keep their values.
- At the edge when state==FULL and y_ready=0: y, s and state are unchanged, and gnt=0.
- Requester contract:
  - Hold req and d_i stable until gnt[i] is seen.
  - Drop req in the cycle after gnt[i], or keep it high to offer the next word.
- A single requester that keeps req high is granted every cycle the output can load.
- Simultaneous drain and load is allowed (state stays FULL), which gives full throughput.

## Timing
- Reset values: y_valid=0, y=0, s=0, gnt=0, state=EMPTY, last=3. With last=3, requester 0 has top priority after reset.
- Latency: req[i] rising in cycle n with the stage EMPTY gives gnt[i] in cycle n, and y=d_i with y_valid=1 in cycle n+1.
- Throughput: one word per cycle while y_ready=1 and any req is set.
- Back-pressure: y_ready=0 while FULL stalls all grants. No word is lost or duplicated.
- Reset asserted in the middle of an operation:
  - Applies at the next edge.
  - A word pending in y is discarded.
  - gnt is forced to 0 during the reset cycle.
- y_ready while EMPTY is ignored.
- y and s change only at edges where gnt≠0.

## Structure
- Package mux4_arb_pkg holds:
  - the state enum type (EMPTY, FULL)
  - the constant NREQ=4
  - a typedef for the 2-bit requester index
- Sub-module rr_pick4 is purely combinational:
  - inputs: req[3:0], last[1:0], en
  - outputs: one-hot gnt[3:0] and encoded idx[1:0]
- Datapath: the team's parameterised mux2 tree, width-generic, instantiated with #(width) and selected by idx, feeding the y register.

## Test plan
- After reset: y_valid=0, y=0, s=0, gnt=0. Assert req=4'b1111 and y_ready=1. Required:
  - gnt sequence 0001, 0010, 0100, 1000, 0001
  - y sequence 'h000, 'h111, 'h222, 'h333 (with d_i='hiii), one per cycle after the first grant
- Single requester: req=4'b0100, d2='hABC, y_ready=1. Required:
  - gnt=0100 every cycle
  - y='hABC, s=2 and y_valid=1 from the second cycle
- Back-pressure: FULL with y='h111, y_ready=0 for 3 cycles, req=4'b1001. Required:
  - gnt=0 and y stable for those 3 cycles
  - on the cycle y_ready=1, gnt goes to the next index after s in round-robin order
- Drain to empty: one word loaded, then req=0 and y_ready=1. Required:
  - y_valid=0 on the next cycle
  - y holds its last value
- Fairness around the pointer: last=2 and req=4'b0101. Required: gnt=0001 (index 0), then gnt=0100 (index 2).
- Reset while FULL: y='h5A5, y_valid=1, assert reset for 1 cycle. Required:
  - next cycle y_valid=0, y=0, s=0
  - first grant afterwards goes to the lowest requesting index
